// File: rtl/key_input_ctrl.sv
// key_input_ctrl: N-channel push-button front end. Each channel has a
// synchroniser, a debouncer, press/release edge detection and an auto-repeat
// engine (initial DAS delay, then ARR period) that emits one-cycle move steps.
//
// Ports:
//   clk            system clock, all logic on posedge
//   rst            asynchronous active-high reset
//   keys_in        raw asynchronous key inputs (polarity set by ACTIVE_LOW)
//   repeat_en      per-key auto-repeat enable, sampled on clk
//   level          debounced pressed state (1 = pressed), registered
//   press          one-cycle pulse on the edge level rises, registered
//   release_pulse  one-cycle pulse on the edge level falls, registered
//   step           one-cycle move pulse: on press, then DAS/ARR repeats, registered
module key_input_ctrl #(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned DAS_CYCLES      = 8000000,
    parameter int unsigned ARR_CYCLES      = 2500000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned CNT_W           = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keys_in,
    input  logic [N_KEYS-1:0] repeat_en,
    output logic [N_KEYS-1:0] level,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] step
);

    // Counters compare against limit-1 so they clear instead of reaching the limit.
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       db_cnt_q, db_cnt_d;
        logic [CNT_W-1:0]       rpt_cnt_q, rpt_cnt_d;
        logic                   lvl_q, lvl_d;
        logic                   press_q, press_d;
        logic                   rel_q, rel_d;
        logic                   step_q, step_d;
        rpt_state_t             st_q, st_d;
        logic                   pressed_c;

        // Synchroniser output normalised so 1 means pressed.
        assign pressed_c = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

        // State registers; sync chain resets to the released raw level.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q    <= {SYNC_STAGES{ACTIVE_LOW}};
                db_cnt_q  <= '0;
                rpt_cnt_q <= '0;
                lvl_q     <= 1'b0;
                press_q   <= 1'b0;
                rel_q     <= 1'b0;
                step_q    <= 1'b0;
                st_q      <= RPT_IDLE;
            end else begin
                sync_q    <= {sync_q[SYNC_STAGES-2:0], keys_in[k]};
                db_cnt_q  <= db_cnt_d;
                rpt_cnt_q <= rpt_cnt_d;
                lvl_q     <= lvl_d;
                press_q   <= press_d;
                rel_q     <= rel_d;
                step_q    <= step_d;
                st_q      <= st_d;
            end
        end

        // Debounce, edge detection and repeat FSM next-state logic.
        always_comb begin
            db_cnt_d  = '0;
            lvl_d     = lvl_q;
            press_d   = 1'b0;
            rel_d     = 1'b0;
            st_d      = st_q;
            rpt_cnt_d = rpt_cnt_q;
            step_d    = 1'b0;

            if (pressed_c != lvl_q) begin
                if (db_cnt_q == DB_LAST) begin
                    lvl_d   = pressed_c;
                    press_d = pressed_c;
                    rel_d   = ~pressed_c;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end

            // press_d/rel_d are this edge's events, so the step lands with the press.
            case (st_q)
                RPT_IDLE: begin
                    rpt_cnt_d = '0;
                    if (press_d) begin
                        step_d = 1'b1;
                        if (repeat_en[k]) st_d = RPT_DELAY;
                    end
                end
                RPT_DELAY: begin
                    if (rel_d || !repeat_en[k]) begin
                        st_d      = RPT_IDLE;
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == DAS_LAST) begin
                        step_d    = 1'b1;
                        st_d      = RPT_REPEAT;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + CNT_ONE;
                    end
                end
                RPT_REPEAT: begin
                    if (rel_d || !repeat_en[k]) begin
                        st_d      = RPT_IDLE;
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == ARR_LAST) begin
                        step_d    = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    st_d      = RPT_IDLE;
                    rpt_cnt_d = '0;
                end
            endcase
        end

        assign level[k]         = lvl_q;
        assign press[k]         = press_q;
        assign release_pulse[k] = rel_q;
        assign step[k]          = step_q;
    end

endmodule
